// File: rtl/apb_arb_master.sv
// apb_arb_master
//   Two-requester round-robin arbiter in front of a single APB master port.
//   A requester handshake (req_valid/req_ready) is accepted in IDLE, the
//   transfer runs SETUP -> ACCESS on APB, and the result is returned as a
//   one-cycle registered rsp_valid pulse with rdata/err to the owning
//   requester.
//   ACCESS waits at most TIMEOUT cycles for pready. If pready is still low in
//   the last of them, the transfer ends with err=1.
//
// Ports
//   clk, rstn                 : clock, synchronous active-low reset
//   mN_req_valid/mN_req_ready : requester N handshake (N = 0, 1)
//   mN_write/addr/wdata       : requester N transfer attributes
//   mN_rsp_valid/rdata/err    : requester N completion (registered)
//   paddr/pwdata/pwrite/psel/penable/prdata/pready : APB master port
module apb_arb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready
);

    // Count value in the final allowed ACCESS cycle.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e      state_q, state_d;

    logic        last_q;      // id granted most recently
    logic        id_q;        // owner of the transfer in flight
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic [7:0]  wait_q;

    logic        m0_rsp_valid_q, m1_rsp_valid_q;
    logic [31:0] m0_rdata_q, m1_rdata_q;
    logic        m0_err_q, m1_err_q;

    logic        grant;
    logic        accept;
    logic        done;
    logic        timeout;

    // Round-robin: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        if (m0_req_valid && m1_req_valid) begin
            grant = ~last_q;
        end else begin
            grant = m1_req_valid;
        end
    end

    // Gated by rstn so no handshake completes on a reset edge.
    assign accept  = rstn && (state_q == StIdle) && (m0_req_valid || m1_req_valid);
    assign done    = (state_q == StAccess) && pready;
    assign timeout = (state_q == StAccess) && !pready && (wait_q == WaitLast);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (done || timeout) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        psel         = (state_q != StIdle);
        penable      = (state_q == StAccess);
        m0_req_ready = accept && !grant;
        m1_req_ready = accept && grant;
    end

    // Datapath, wait counter and response registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q         <= 1'b1;  // m0 wins the first tie
            id_q           <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            pwrite_q       <= 1'b0;
            wait_q         <= '0;
            m0_rsp_valid_q <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
            m0_err_q       <= 1'b0;
            m1_err_q       <= 1'b0;
        end else begin
            if (accept) begin
                id_q     <= grant;
                last_q   <= grant;
                paddr_q  <= grant ? m1_addr  : m0_addr;
                pwdata_q <= grant ? m1_wdata : m0_wdata;
                pwrite_q <= grant ? m1_write : m0_write;
            end

            if (state_q == StSetup) begin
                wait_q <= '0;
            end else if ((state_q == StAccess) && !pready) begin
                wait_q <= wait_q + 8'd1;
            end

            m0_rsp_valid_q <= (done || timeout) && !id_q;
            m1_rsp_valid_q <= (done || timeout) && id_q;

            // rdata/err only change on a completion for that requester.
            if ((done || timeout) && !id_q) begin
                m0_rdata_q <= (done && !pwrite_q) ? prdata : 32'h0;
                m0_err_q   <= timeout;
            end
            if ((done || timeout) && id_q) begin
                m1_rdata_q <= (done && !pwrite_q) ? prdata : 32'h0;
                m1_err_q   <= timeout;
            end
        end
    end

    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign pwrite       = pwrite_q;
    assign m0_rsp_valid = m0_rsp_valid_q;
    assign m1_rsp_valid = m1_rsp_valid_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign m0_err       = m0_err_q;
    assign m1_err       = m1_err_q;

endmodule
